// File: rtl/sram_req_arbiter_pkg.sv
// sram_req_arbiter_pkg: shared FSM/owner encodings and request-bus layout
// Request bus layout, MSB to LSB: {wr, size[1:0], wstrb[3:0], addr[ADDR_W-1:0], wdata[DATA_W-1:0]}
package sram_req_arbiter_pkg;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_RESP = 2'd2} state_e;
  typedef enum logic {OWN_INST = 1'b0, OWN_DATA = 1'b1} owner_e;
  localparam int CTRL_W = 7;
endpackage

// File: rtl/sram_req_grant.sv
// sram_req_grant: data-priority grant with an inst starvation limit
// Ports: clk, resetn (sync active-low), en (arbiter idle), inst_req/data_req in;
//        grant_inst/grant_data out (combinational, mutually exclusive)
module sram_req_grant import sram_req_arbiter_pkg::*; #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic resetn,
  input  logic en,
  input  logic inst_req,
  input  logic data_req,
  output logic grant_inst,
  output logic grant_data
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    grant_data = en && data_req && !(inst_req && cnt_q == LIM);
    grant_inst = en && inst_req && !grant_data;
    cnt_d = (grant_data && inst_req) ? ((cnt_q == LIM) ? cnt_q : cnt_q + 1'b1) :
            (grant_inst || grant_data) ? '0 : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (!resetn) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/sram_req_arbiter.sv
// sram_req_arbiter: shares one SRAM-like port between inst and data requesters
// Ports: clk, resetn (sync active-low); inst_*/data_* requester sides
//        (req, req_bus in; addr_ok, data_ok, rdata out); mem_* memory side
//        (req, req_bus out; addr_ok, data_ok, rdata in). One transaction in flight.
module sram_req_arbiter import sram_req_arbiter_pkg::*; #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int STARVE_LIMIT = 4,
  localparam int REQ_BUS_WD = CTRL_W + ADDR_W + DATA_W
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  inst_req,
  input  logic [REQ_BUS_WD-1:0] inst_req_bus,
  output logic                  inst_addr_ok,
  output logic                  inst_data_ok,
  output logic [DATA_W-1:0]     inst_rdata,
  input  logic                  data_req,
  input  logic [REQ_BUS_WD-1:0] data_req_bus,
  output logic                  data_addr_ok,
  output logic                  data_data_ok,
  output logic [DATA_W-1:0]     data_rdata,
  output logic                  mem_req,
  output logic [REQ_BUS_WD-1:0] mem_req_bus,
  input  logic                  mem_addr_ok,
  input  logic                  mem_data_ok,
  input  logic [DATA_W-1:0]     mem_rdata
);
  state_e state_q, state_d;
  owner_e owner_q, owner_d;
  logic [REQ_BUS_WD-1:0] bus_q, bus_d;
  logic gi, gd, resp_i, resp_d;
  // Grants are suppressed while resetn is low so no requester sees an accept that reset discards.
  sram_req_grant #(.STARVE_LIMIT(STARVE_LIMIT)) u_grant (
    .clk        (clk),
    .resetn     (resetn),
    .en         (resetn && state_q == S_IDLE),
    .inst_req   (inst_req),
    .data_req   (data_req),
    .grant_inst (gi),
    .grant_data (gd)
  );
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    bus_d = bus_q;
    if (gi || gd) begin
      state_d = S_REQ;
      owner_d = gd ? OWN_DATA : OWN_INST;
      bus_d = gd ? data_req_bus : inst_req_bus;
    end
    if (state_q == S_REQ && mem_addr_ok) state_d = S_RESP;
    if (state_q == S_RESP && mem_data_ok) state_d = S_IDLE;
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      owner_q <= OWN_INST;
      bus_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      bus_q <= bus_d;
    end
  end
  assign resp_i = state_q == S_RESP && owner_q == OWN_INST;
  assign resp_d = state_q == S_RESP && owner_q == OWN_DATA;
  assign inst_addr_ok = gi;
  assign data_addr_ok = gd;
  assign mem_req = state_q == S_REQ;
  assign mem_req_bus = mem_req ? bus_q : '0;
  assign inst_data_ok = resp_i && mem_data_ok;
  assign data_data_ok = resp_d && mem_data_ok;
  assign inst_rdata = resp_i ? mem_rdata : '0;
  assign data_rdata = resp_d ? mem_rdata : '0;
endmodule

// File: tb/tb_sram_req_arbiter.sv
// tb_sram_req_arbiter: transaction-level model check plus directed literal checks
module tb_sram_req_arbiter;
  localparam int AW = 32, DW = 32, SL = 4, BW = 7 + AW + DW;
  logic clk = 0, resetn = 0;
  logic inst_req = 0, data_req = 0;
  logic [BW-1:0] inst_req_bus = '0, data_req_bus = '0;
  logic inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok, mem_req;
  logic [DW-1:0] inst_rdata, data_rdata;
  logic [BW-1:0] mem_req_bus;
  logic auto_mem = 0, man_aok = 0, man_dok = 0, pend = 0;
  logic [DW-1:0] mem_rdata = '0;
  logic mem_addr_ok, mem_data_ok;
  int npass = 0, ntot = 0;
  logic chk_en = 0, log_en = 0;
  int lcnt = 0;
  logic [15:0] lbits = '0;
  logic m_busy = 0, m_acc = 0, m_own = 0;
  logic [BW-1:0] m_bus = '0;
  int m_streak = 0;

  sram_req_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_req_bus(inst_req_bus), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_req_bus(data_req_bus), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_req_bus(mem_req_bus), .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Zero-wait memory: accept immediately, respond the following cycle.
  assign mem_addr_ok = auto_mem ? mem_req : man_aok;
  assign mem_data_ok = auto_mem ? pend : man_dok;
  always @(posedge clk) pend <= resetn && auto_mem && mem_req && mem_addr_ok;

  function automatic logic [BW-1:0] mk(logic wr, logic [1:0] sz, logic [3:0] ws, logic [31:0] a, logic [31:0] d);
    return {wr, sz, ws, a, d};
  endfunction

  // Winner of this cycle: 0 none, 1 inst, 2 data.
  function automatic int win();
    if (!resetn || m_busy) return 0;
    if (data_req && !(inst_req && m_streak >= SL)) return 2;
    return inst_req ? 1 : 0;
  endfunction

  task automatic chk(string nm, logic [BW-1:0] act, logic [BW-1:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
  endtask

  // Model: a single transaction record (owner, bus, accepted?) plus the inst starvation streak.
  always @(posedge clk) begin
    int w;
    w = win();
    if (!resetn) begin
      m_busy <= 0;
      m_acc <= 0;
      m_streak <= 0;
    end else if (w != 0) begin
      m_busy <= 1;
      m_acc <= 0;
      m_own <= (w == 2);
      m_bus <= (w == 2) ? data_req_bus : inst_req_bus;
      m_streak <= (w == 2 && inst_req) ? m_streak + 1 : 0;
    end else if (m_busy && !m_acc && mem_addr_ok) m_acc <= 1;
    else if (m_busy && m_acc && mem_data_ok) m_busy <= 0;
  end

  always @(negedge clk) begin
    int w;
    logic rq, rs;
    w = win();
    rq = m_busy && !m_acc;
    rs = m_busy && m_acc;
    if (chk_en) begin
      chk("inst_addr_ok", BW'(inst_addr_ok), BW'(w == 1));
      chk("data_addr_ok", BW'(data_addr_ok), BW'(w == 2));
      chk("mem_req", BW'(mem_req), BW'(rq));
      chk("mem_req_bus", mem_req_bus, rq ? m_bus : '0);
      chk("inst_data_ok", BW'(inst_data_ok), BW'(rs && !m_own && mem_data_ok));
      chk("data_data_ok", BW'(data_data_ok), BW'(rs && m_own && mem_data_ok));
      chk("inst_rdata", BW'(inst_rdata), BW'((rs && !m_own) ? mem_rdata : '0));
      chk("data_rdata", BW'(data_rdata), BW'((rs && m_own) ? mem_rdata : '0));
    end
    if (log_en && (inst_addr_ok || data_addr_ok)) begin
      lbits = {lbits[14:0], data_addr_ok};
      lcnt++;
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_grants(int n);
    for (int i = 0; i < 80 && lcnt < n; i++) @(negedge clk);
    #1;
    chk("grant_count", BW'(lcnt), BW'(n));
  endtask

  initial begin
    inst_req = 1;
    data_req = 1;
    tick(2);
    chk_en = 1;
    @(negedge clk);
    chk("rst_addr_ok", BW'({inst_addr_ok, data_addr_ok}), BW'(0));
    chk("rst_mem_req", BW'(mem_req), BW'(0));
    chk("rst_mem_bus", mem_req_bus, '0);
    inst_req = 0;
    data_req = 0;
    tick(1);
    resetn = 1;
    tick(1);
    // 1: inst read, accept after 2 wait cycles, response one cycle later
    inst_req = 1;
    inst_req_bus = mk(0, 2'd2, 4'h0, 32'h1c000000, 32'h0);
    @(negedge clk);
    chk("t1_inst_aok", BW'(inst_addr_ok), BW'(1));
    tick(1);
    inst_req = 0;
    @(negedge clk);
    chk("t1_mreq_c1", BW'(mem_req), BW'(1));
    tick(1);
    @(negedge clk);
    chk("t1_mreq_c2", BW'(mem_req), BW'(1));
    tick(1);
    man_aok = 1;
    @(negedge clk);
    chk("t1_mreq_c3", BW'(mem_req), BW'(1));
    tick(1);
    man_aok = 0;
    man_dok = 1;
    mem_rdata = 32'h02800000;
    @(negedge clk);
    chk("t1_inst_dok", BW'(inst_data_ok), BW'(1));
    chk("t1_inst_rdata", BW'(inst_rdata), BW'(32'h02800000));
    chk("t1_data_dok", BW'(data_data_ok), BW'(0));
    tick(1);
    man_dok = 0;
    // 2: continuous contention, zero-wait memory
    auto_mem = 1;
    mem_rdata = 32'h12345678;
    inst_req = 1;
    data_req = 1;
    inst_req_bus = mk(0, 2'd2, 4'h0, 32'h1c000100, 32'h0);
    data_req_bus = mk(0, 2'd2, 4'h0, 32'h00001000, 32'h0);
    lcnt = 0;
    lbits = '0;
    log_en = 1;
    wait_grants(10);
    tick(1);
    inst_req = 0;
    data_req = 0;
    log_en = 0;
    chk("t2_order", BW'(lbits[9:0]), BW'(10'b1111011110));
    tick(4);
    auto_mem = 0;
    tick(1);
    // 3: data write held stable while memory stalls
    data_req = 1;
    data_req_bus = mk(1, 2'd2, 4'b0011, 32'h80000004, 32'hdeadbeef);
    tick(1);
    data_req = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t3_bus", mem_req_bus, mk(1, 2'd2, 4'b0011, 32'h80000004, 32'hdeadbeef));
      tick(1);
    end
    man_aok = 1;
    tick(1);
    man_aok = 0;
    man_dok = 1;
    tick(1);
    man_dok = 0;
    // 4: early mem_data_ok during REQ is ignored
    inst_req = 1;
    inst_req_bus = mk(0, 2'd2, 4'h0, 32'h1c000200, 32'h0);
    tick(1);
    inst_req = 0;
    man_dok = 1;
    @(negedge clk);
    chk("t4_no_dok", BW'(inst_data_ok), BW'(0));
    tick(1);
    man_dok = 0;
    @(negedge clk);
    chk("t4_still_req", BW'(mem_req), BW'(1));
    tick(1);
    man_aok = 1;
    tick(1);
    man_aok = 0;
    man_dok = 1;
    mem_rdata = 32'h0badf00d;
    @(negedge clk);
    chk("t4_dok", BW'(inst_data_ok), BW'(1));
    tick(1);
    man_dok = 0;
    // 5: reset during RESP, pending data_req granted right after release
    data_req = 1;
    data_req_bus = mk(0, 2'd2, 4'h0, 32'h00002000, 32'h0);
    tick(1);
    data_req = 0;
    man_aok = 1;
    tick(1);
    man_aok = 0;
    data_req = 1;
    resetn = 0;
    tick(1);
    @(negedge clk);
    chk("t5_rst_outs", BW'({inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, mem_req}), BW'(0));
    chk("t5_rst_bus", mem_req_bus, '0);
    tick(1);
    resetn = 1;
    @(negedge clk);
    chk("t5_regrant", BW'(data_addr_ok), BW'(1));
    tick(1);
    data_req = 0;
    man_aok = 1;
    tick(1);
    man_aok = 0;
    man_dok = 1;
    tick(1);
    man_dok = 0;
    // 6: inst drops its request unserved; starve streak must survive
    auto_mem = 1;
    inst_req = 1;
    data_req = 1;
    lcnt = 0;
    lbits = '0;
    log_en = 1;
    wait_grants(3);
    tick(1);
    inst_req = 0;
    data_req = 0;
    tick(6);
    @(negedge clk);
    chk("t6_no_mreq", BW'(mem_req), BW'(0));
    lcnt = 0;
    lbits = '0;
    tick(1);
    inst_req = 1;
    data_req = 1;
    wait_grants(2);
    tick(1);
    inst_req = 0;
    data_req = 0;
    log_en = 0;
    chk("t6_order", BW'(lbits[1:0]), BW'(2'b10));
    tick(4);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
